// File: rtl/ball_control.sv
// ball_control: owns the square (ball) position and direction, moves it across
// the playfield one pixel per axis per movement tick, bounces it off the top and
// bottom walls and both paddles, detects misses and re-serves from the centre.
//
// Ports:
//   clk_0        pixel clock (single clock domain)
//   rst          synchronous active-high reset
//   reset_game   return square to centre and hold in IDLE
//   mode_choice  0 = no game (hold), 1 or 2 = game running
//   p1_x, p1_y   left paddle left/top edge
//   p2_x, p2_y   right paddle left/top edge
//   sq_xpos      square left edge
//   sq_ypos      square top edge
//   sq_xveldir   1 = moving right, 0 = moving left
//   sq_yveldir   1 = moving down, 0 = moving up
//   sq_missed    one-cycle pulse on a miss
//   miss_side    0 = left missed, 1 = right missed; held until the next miss
module ball_control #(
  parameter int CLK_HZ      = 25_175_000,
  parameter int H_VIDEO     = 640,
  parameter int V_VIDEO     = 480,
  parameter int SQ_SIZE     = 8,
  parameter int PDL_WIDTH   = 8,
  parameter int PDL_HEIGHT  = 96,
  parameter int BALL_SPEED  = 400,
  parameter int SERVE_TICKS = 200
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       reset_game,
  input  logic [1:0] mode_choice,
  input  logic [9:0] p1_x,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_x,
  input  logic [9:0] p2_y,
  output logic [9:0] sq_xpos,
  output logic [9:0] sq_ypos,
  output logic       sq_xveldir,
  output logic       sq_yveldir,
  output logic       sq_missed,
  output logic       miss_side
);

  localparam int PSC_LIMIT = CLK_HZ / BALL_SPEED;
  localparam int PSC_W     = (PSC_LIMIT > 0) ? $clog2(PSC_LIMIT + 1) : 1;
  localparam int CNT_W     = (SERVE_TICKS > 0) ? $clog2(SERVE_TICKS + 1) : 1;
  localparam logic [9:0] CX = 10'(H_VIDEO / 2 - SQ_SIZE / 2);
  localparam logic [9:0] CY = 10'(V_VIDEO / 2 - SQ_SIZE / 2);

  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_PLAY, S_MISS} state_t;

  state_t           state_q, state_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             xdir_q, xdir_d, ydir_q, ydir_d;
  logic             side_q, side_d;

  // 11-bit sums so that right/bottom edges near 1023 cannot wrap.
  logic [10:0] x_right, y_bot, p1_right, p1_bot, p2_bot;
  logic        tick, hit_l, hit_r, miss_l, miss_r, xdir_n, ydir_n;
  logic [CNT_W-1:0] cnt_inc;

  assign x_right  = {1'b0, x_q}  + 11'(SQ_SIZE);
  assign y_bot    = {1'b0, y_q}  + 11'(SQ_SIZE);
  assign p1_right = {1'b0, p1_x} + 11'(PDL_WIDTH);
  assign p1_bot   = {1'b0, p1_y} + 11'(PDL_HEIGHT);
  assign p2_bot   = {1'b0, p2_y} + 11'(PDL_HEIGHT);

  assign tick    = (psc_q == PSC_W'(PSC_LIMIT));
  assign cnt_inc = cnt_q + 1'b1;

  // All collision tests look at the pre-move position.
  assign hit_l  = !xdir_q && ({1'b0, x_q} == p1_right)
                  && (y_bot > {1'b0, p1_y}) && ({1'b0, y_q} < p1_bot);
  assign hit_r  = xdir_q && (x_right == {1'b0, p2_x})
                  && (y_bot > {1'b0, p2_y}) && ({1'b0, y_q} < p2_bot);
  // A paddle hit always wins over the miss on the same tick.
  assign miss_l = !xdir_q && (x_q == 10'd0) && !hit_l;
  assign miss_r = xdir_q && (x_right == 11'(H_VIDEO)) && !hit_r;

  assign xdir_n = hit_l ? 1'b1 : (hit_r ? 1'b0 : xdir_q);
  assign ydir_n = ydir_q ? !(y_bot >= 11'(V_VIDEO - 1)) : (y_q == 10'd0);

  always_comb begin
    state_d = state_q;
    psc_d   = tick ? '0 : psc_q + 1'b1;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    xdir_d  = xdir_q;
    ydir_d  = ydir_q;
    side_d  = side_q;

    case (state_q)
      S_IDLE: begin
        x_d     = CX;
        y_d     = CY;
        psc_d   = '0;
        cnt_d   = '0;
        state_d = S_SERVE;  // abort override below keeps us here when held
      end
      S_SERVE: begin
        x_d = CX;
        y_d = CY;
        if (tick) begin
          if (cnt_inc == CNT_W'(SERVE_TICKS)) begin
            state_d = S_PLAY;
            cnt_d   = '0;
            ydir_d  = !ydir_q;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_PLAY: begin
        if (tick) begin
          if (miss_l || miss_r) begin
            // Freeze position; only the side is recorded.
            state_d = S_MISS;
            side_d  = miss_r;
          end else begin
            xdir_d = xdir_n;
            ydir_d = ydir_n;
            x_d    = xdir_n ? x_q + 10'd1 : x_q - 10'd1;
            y_d    = ydir_n ? y_q + 10'd1 : y_q - 10'd1;
          end
        end
      end
      S_MISS: begin
        // Next serve heads toward the side that just missed.
        x_d     = CX;
        y_d     = CY;
        xdir_d  = side_q;
        psc_d   = '0;
        cnt_d   = '0;
        state_d = S_SERVE;
      end
      default: state_d = S_IDLE;
    endcase

    if (reset_game || mode_choice == 2'd0) begin
      state_d = S_IDLE;
      x_d     = CX;
      y_d     = CY;
      psc_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_0) begin
    if (rst) begin
      state_q <= S_IDLE;
      psc_q   <= '0;
      cnt_q   <= '0;
      x_q     <= CX;
      y_q     <= CY;
      xdir_q  <= 1'b1;
      ydir_q  <= 1'b1;
      side_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xdir_q  <= xdir_d;
      ydir_q  <= ydir_d;
      side_q  <= side_d;
    end
  end

  assign sq_xpos    = x_q;
  assign sq_ypos    = y_q;
  assign sq_xveldir = xdir_q;
  assign sq_yveldir = ydir_q;
  assign sq_missed  = (state_q == S_MISS);
  assign miss_side  = side_q;

endmodule

// File: tb/tb_ball_control.sv
// tb_ball_control: randomized bench for ball_control with a behavioural model.
// The model tracks the game as phases with elapsed-cycle ages and signed
// velocities; outputs are compared every cycle plus directed spot checks.
module tb_ball_control;

  localparam int PSC   = 4;   // 1600 / 400
  localparam int ST    = 3;
  localparam int CXM   = 316;
  localparam int CYM   = 236;

  logic       clk_0 = 1'b0;
  logic       rst = 1'b1;
  logic       reset_game = 1'b0;
  logic [1:0] mode_choice = 2'd0;
  logic [9:0] p1_x = 10'd16, p1_y = 10'd0, p2_x = 10'd608, p2_y = 10'd0;
  logic [9:0] sq_xpos, sq_ypos;
  logic       sq_xveldir, sq_yveldir, sq_missed, miss_side;

  ball_control #(
    .CLK_HZ(1600), .BALL_SPEED(400), .SERVE_TICKS(ST)
  ) dut (
    .clk_0(clk_0), .rst(rst), .reset_game(reset_game), .mode_choice(mode_choice),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .sq_xpos(sq_xpos), .sq_ypos(sq_ypos), .sq_xveldir(sq_xveldir),
    .sq_yveldir(sq_yveldir), .sq_missed(sq_missed), .miss_side(miss_side)
  );

  always #5 clk_0 = ~clk_0;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 serve, 2 play, 3 miss
  int m_phase = 0, m_age = 0, m_ticks = 0;
  int m_x = CXM, m_y = CYM, m_dx = 1, m_dy = 1, m_side = 0;

  function automatic bit m_tick();
    return (m_age % (PSC + 1)) == PSC;
  endfunction

  function automatic bit overlap(input int py);
    return (m_y + 8 > py) && (m_y < py + 96);
  endfunction

  // 0 = keep going, 1 = left hit, 2 = right hit, 3 = left miss, 4 = right miss
  function automatic int classify();
    if (m_dx < 0 && m_x == int'(p1_x) + 8 && overlap(int'(p1_y))) return 1;
    if (m_dx > 0 && m_x + 8 == int'(p2_x) && overlap(int'(p2_y))) return 2;
    if (m_dx < 0 && m_x == 0) return 3;
    if (m_dx > 0 && m_x + 8 == 640) return 4;
    return 0;
  endfunction

  task automatic model_step();
    int c, ndx, ndy;
    bit t;
    if (rst) begin
      m_phase = 0; m_age = 0; m_ticks = 0; m_x = CXM; m_y = CYM;
      m_dx = 1; m_dy = 1; m_side = 0;
    end else if (reset_game || mode_choice == 2'd0) begin
      m_phase = 0; m_age = 0; m_ticks = 0; m_x = CXM; m_y = CYM;
    end else begin
      case (m_phase)
        0: begin m_phase = 1; m_age = 0; end
        1: begin
          t = m_tick();
          m_age++;
          if (t) begin
            m_ticks++;
            if (m_ticks == ST) begin
              m_phase = 2; m_age = 0; m_ticks = 0; m_dy = -m_dy;
            end
          end
        end
        2: begin
          t = m_tick();
          m_age++;
          if (t) begin
            c = classify();
            if (c >= 3) begin
              m_phase = 3; m_age = 0; m_side = (c == 4) ? 1 : 0;
              $display("miss side=%0d at x=%0d y=%0d t=%0t", m_side, m_x, m_y, $time);
            end else begin
              ndx = (c == 1) ? 1 : (c == 2) ? -1 : m_dx;
              ndy = m_dy;
              if (m_dy > 0 && m_y + 8 >= 479) ndy = -1;
              else if (m_dy < 0 && m_y == 0) ndy = 1;
              m_x += ndx; m_y += ndy; m_dx = ndx; m_dy = ndy;
            end
          end
        end
        default: begin
          m_x = CXM; m_y = CYM; m_dx = (m_side != 0) ? 1 : -1;
          m_phase = 1; m_age = 0; m_ticks = 0;
        end
      endcase
    end
  endtask

  always @(posedge clk_0) begin
    model_step();
    #1;
    if (chk_en) begin
      chk("xpos", int'(sq_xpos), m_x);
      chk("ypos", int'(sq_ypos), m_y);
      chk("xdir", int'(sq_xveldir), (m_dx > 0) ? 1 : 0);
      chk("ydir", int'(sq_yveldir), (m_dy > 0) ? 1 : 0);
      chk("missed", int'(sq_missed), (m_phase == 3) ? 1 : 0);
      chk("side", int'(miss_side), m_side);
    end
  end

  // ---------------- stimulus ----------------
  int trk1 = 0, trk2 = 0;  // 0 static, 1 follow ball, 2 stay away from ball

  function automatic logic [9:0] pdl_y(input int how, input logic [9:0] cur);
    int v;
    if (how == 1) begin
      v = m_y - 44;
      if (v < 0) v = 0;
      if (v > 384) v = 384;
      return 10'(v);
    end
    if (how == 2) return (m_y < 200) ? 10'd380 : 10'd0;
    return cur;
  endfunction

  task automatic cycle();
    @(negedge clk_0);
    p1_y = pdl_y(trk1, p1_y);
    p2_y = pdl_y(trk2, p2_y);
  endtask

  initial begin
    int n, first_y, first_x, len, pulse_at, kind;
    bit found;

    // Reset with mode 0, then hold for 1000 cycles.
    cycle(); rst = 1'b1; mode_choice = 2'd0;
    cycle(); cycle();
    chk_en = 1'b1;
    rst = 1'b0;
    chk("rst_x", int'(sq_xpos), 316);
    chk("rst_y", int'(sq_ypos), 236);
    chk("rst_xdir", int'(sq_xveldir), 1);
    chk("rst_ydir", int'(sq_yveldir), 1);
    chk("rst_missed", int'(sq_missed), 0);
    repeat (1000) cycle();
    chk("hold_x", int'(sq_xpos), 316);
    chk("hold_y", int'(sq_ypos), 236);
    $display("reset and hold done");

    // Serve timing; p2 follows the ball at x=608, p1 keeps away.
    p1_x = 10'd16; p2_x = 10'd608; trk1 = 2; trk2 = 1;
    mode_choice = 2'd1;
    first_y = 0; first_x = 0;
    for (n = 1; n <= 100; n++) begin
      cycle();
      if (first_y == 0 && !sq_yveldir) first_y = n;
      if (sq_xpos != 10'd316) begin first_x = n; break; end
    end
    chk("serve_ydir_cyc", first_y, 16);
    chk("serve_move_cyc", first_x, 21);
    chk("serve_first_x", int'(sq_xpos), 317);
    chk("serve_first_y", int'(sq_ypos), 235);
    $display("serve: ydir flip cycle %0d, first move cycle %0d", first_y, first_x);

    // Right paddle hit after the top-wall bounce.
    found = 1'b0;
    for (n = 0; n < 3000; n++) begin
      cycle();
      if (!sq_xveldir) begin found = 1'b1; break; end
    end
    chk("rhit_seen", int'(found), 1);
    chk("rhit_x", int'(sq_xpos), 599);
    chk("rhit_missed", int'(sq_missed), 0);
    $display("right hit at x=%0d y=%0d", sq_xpos, sq_ypos);

    // Left miss with p1 out of the way.
    found = 1'b0;
    for (n = 0; n < 5000; n++) begin
      cycle();
      if (sq_missed) begin found = 1'b1; break; end
    end
    chk("lmiss_seen", int'(found), 1);
    chk("lmiss_side", int'(miss_side), 0);
    cycle();
    chk("lmiss_pulse_len", int'(sq_missed), 0);
    chk("lmiss_centre_x", int'(sq_xpos), 316);
    chk("lmiss_serve_dir", int'(sq_xveldir), 0);
    $display("left miss, reserve toward left");

    // Mid-play abort with reset_game.
    repeat (300) cycle();
    reset_game = 1'b1;
    cycle();
    reset_game = 1'b0;
    chk("abort_x", int'(sq_xpos), 316);
    chk("abort_y", int'(sq_ypos), 236);
    chk("abort_missed", int'(sq_missed), 0);
    $display("reset_game abort done");

    // rst landing on the very edge that would register a miss.
    found = 1'b0;
    for (n = 0; n < 8000; n++) begin
      cycle();
      if (m_phase == 2 && m_tick() && classify() >= 3) begin
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_on_miss", int'(sq_missed), 0);
        found = 1'b1;
        break;
      end
    end
    chk("rst_on_miss_seen", int'(found), 1);
    $display("rst coincident with miss done");

    // Randomized segments.
    for (int seg = 0; seg < 20; seg++) begin
      kind = $urandom_range(0, 7);
      mode_choice = (kind == 0) ? 2'd0 : 2'($urandom_range(1, 2));
      trk1 = $urandom_range(0, 2);
      trk2 = $urandom_range(0, 2);
      p1_x = 10'($urandom_range(0, 40));
      p2_x = 10'($urandom_range(592, 632));
      p1_y = 10'($urandom_range(0, 384));
      p2_y = 10'($urandom_range(0, 384));
      len = $urandom_range(300, 2500);
      pulse_at = $urandom_range(0, len - 1);
      kind = $urandom_range(0, 5);
      $display("seg %0d: mode=%0d trk=%0d/%0d p1=(%0d,%0d) p2=(%0d,%0d) len=%0d ev=%0d",
               seg, mode_choice, trk1, trk2, p1_x, p1_y, p2_x, p2_y, len, kind);
      for (int c = 0; c < len; c++) begin
        cycle();
        reset_game = (kind == 0 && c == pulse_at);
        rst        = (kind == 1 && c == pulse_at);
      end
      cycle();
      reset_game = 1'b0;
      rst = 1'b0;
    end

    repeat (3) cycle();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
